sdr_dev_responder: RTL
======================

Name: sdr_dev_responder

Overview:
- Synthesizable SDRAM device-side responder: the memory end of the SDRAM bus, used as the DUT-side memory in controller benches and in FPGA loopback builds.
- Decodes `{sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}` commands.
- Tracks per-bank open rows and holds the mode register (burst length, CAS latency).
- Stores write bursts in a small on-chip array; returns read bursts after CAS latency with a driven output enable.
- Flags protocol violations on a sticky error output.

Parameters:
- SDR_DW, 16, SDRAM data width
- SDR_BW, 2, byte lanes (SDR_DW/8)
- COL_W, 8, modelled column address bits (sdr_addr[COL_W-1:0])
- ROW_W, 2, modelled row bits (sdr_addr[ROW_W-1:0] at ACTIVE); array depth = 4*2^(ROW_W+COL_W)

Ports:
- sdram_clk  in  1  device clock; all logic on rising edge
- sdram_resetn  in  1  asynchronous active-low reset
- sdr_cke  in  1  clock enable; when 0, all state frozen, command ignored
- sdr_cs_n  in  1  chip select
- sdr_ras_n  in  1  row strobe
- sdr_cas_n  in  1  column strobe
- sdr_we_n  in  1  write enable
- sdr_ba  in  2  bank address
- sdr_addr  in  13  row/column/mode address; A10 = auto-precharge/all-banks
- sdr_dqm  in  SDR_BW  byte mask
- sdr_dq_in  in  SDR_DW  sampled DQ
- sdr_dq_out  out  SDR_DW  read data
- sdr_dq_oe  out  1  drive enable for sdr_dq_out (tristate is outside this block)
- cmd_err  out  1  sticky protocol-error flag
- cmd_err_code  out  3  code of the first error since reset

Behaviour:
- Reset (async, sdram_resetn=0) values:
  - sdr_dq_out=0, sdr_dq_oe=0, cmd_err=0, cmd_err_code=0.
  - All banks idle; mode register = BL1, CL2.
  - Array contents undefined.
- Command decode matches the bus encoding:
  - LMR=0000, REF=0001, PRE=0010, ACT=0011, WR=0100, RD=0101, BST=0110.
  - NOP=0111 or cs_n=1.
- Per-bank FSM: IDLE -ACT-> ACTIVE (latch row) -PRE-> IDLE.
  - ACT on an ACTIVE bank: err code 1, row not changed.
- PRE with A10=1 closes all banks. PRE on an idle bank is legal (no-op).
- RD/WR to an IDLE bank: err 2, command ignored.
- REF or LMR with any bank ACTIVE: err 3, command ignored.
- LMR decode:
  - A[2:0]: 0/1/2/3 → BL 1/2/4/8; other values → BL1 and err 4.
  - A[6:4]: 2 or 3 → CL; other values → CL2 and err 4.
  - Only sequential burst type is modelled; A3 ignored.
- Word address = {ba, open_row[ROW_W-1:0], col}.
  - Burst column increments modulo BL within the aligned BL block (wrap on low log2(BL) bits).
- WRITE:
  - Data is captured the same edge as the WR command and on the following BL-1 edges.
  - Byte lane written only when its dqm bit = 0.
- READ timing:
  - RD sampled at edge N → sdr_dq_out/sdr_dq_oe=1 valid from edge N+CL-1 (sampled by the controller at edge N+CL), for BL cycles.
  - sdr_dq_oe returns to 0 after the last beat.
  - Read DQM has 2-cycle latency: a masked beat drives oe=0 for that beat.
- Interruption:
  - A new RD/WR, PRE to the bursting bank, or BST terminates the current burst.
  - Read data already in the CL pipeline still emerges, up to CL-1 beats.
  - A new RD starts its own pipeline.
  - A WR during read data-out: err 5; the write proceeds and oe is forced 0 from that edge.
- Auto-precharge (A10=1 on RD/WR) closes the bank after the last beat.
- Simultaneous events: at most one command per edge, so a command and a burst beat on the same edge both take effect, command first.
- cmd_err is sticky; cmd_err_code records the first error only.
- cke=0 holds all counters/pipelines; outputs keep their values.

Optional Feature:
- Macro: SDR_DEV_INIT_CHK_EN.
- Defined:
  - Until the first LMR after reset, only NOP/PRE/REF/LMR are legal.
  - ACT/RD/WR/BST before that: err 6, command ignored.
- Undefined:
  - No init check; reset-default mode (BL1, CL2) is usable immediately.

Test Plan:
- LMR A=0x021 (BL2,CL2); ACT ba0 row1; WR col 0x10 data 0xAAAA,0x5555 dqm 00 → RD col 0x10 returns 0xAAAA,0x5555; first beat sampled 2 edges after RD; oe high exactly 2 cycles.
- LMR A=0x033 (BL8,CL3); RD col 0x06 → column order 6,7,0,1,2,3,4,5; first beat 3 edges after RD.
- WR with dqm=2'b10 data 0x1234 over 0xFFFF → read 0xFF34.
- ACT ba1 twice → cmd_err=1, code=1; subsequent RD from ba2 (idle) → code stays 1.
- BL8 read; BST 2 cycles after data start → CL-1 further beats, then oe=0; PRE A10=1 then REF → no error.
- With SDR_DEV_INIT_CHK_EN: ACT before any LMR → cmd_err=1, code=6; without the macro → no error, BL1/CL2 read works.

Source files
------------

// File: rtl/sdr_dev_responder.sv
// SDRAM device-side responder: command decode, per-bank rows, mode register, burst array, CL read pipe.
// Define SDR_DEV_INIT_CHK_EN to reject ACT/RD/WR/BST (error 6) until the first LMR after reset.
module sdr_dev_responder #(
    parameter int SDR_DW = 16,
    parameter int SDR_BW = 2,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 2
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_cke,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [1:0]        sdr_ba,
    input  logic [12:0]       sdr_addr,
    input  logic [SDR_BW-1:0] sdr_dqm,
    input  logic [SDR_DW-1:0] sdr_dq_in,
    output logic [SDR_DW-1:0] sdr_dq_out,
    output logic              sdr_dq_oe,
    output logic              cmd_err,
    output logic [2:0]        cmd_err_code
);
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_t;
    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_ACT_OPEN   = 3'd1,
        ERR_BANK_IDLE  = 3'd2,
        ERR_BANKS_OPEN = 3'd3,
        ERR_MODE       = 3'd4,
        ERR_WR_RD      = 3'd5,
        ERR_INIT       = 3'd6
    } err_t;

    bank_state_t          bank_st [4];
    logic [ROW_W-1:0]     bank_row [4];
    logic [1:0]           bl_code;
    logic                 cl3;
`ifdef SDR_DEV_INIT_CHK_EN
    logic                 mode_set;
`endif

    logic                 bst_active, bst_wr, bst_ap;
    logic [1:0]           bst_bank;
    logic [COL_W-1:0]     bst_col;
    logic [2:0]           bst_cnt;

    logic                 p0_v, p1_v;
    logic [AW-1:0]        p0_a, p1_a;
    logic [SDR_BW-1:0]    dqm_d;
    logic [SDR_DW-1:0]    mem [DEPTH];

    logic [3:0]           cmd;
    logic                 is_lmr, is_ref, is_pre, is_act, is_wr, is_rd, is_bst;
    logic                 any_open, bank_open, init_block, rd_ok, wr_ok, mode_bad, rd_busy, term;
    err_t                 err_now;
    logic [2:0]           bl_mask;
    logic [COL_W-1:0]     mask_ext, beat_col, col_next;
    logic [1:0]           beat_bank;
    logic                 beat_v, beat_wr;
    logic [AW-1:0]        beat_addr;
    logic                 src_v;
    logic [AW-1:0]        src_a;
    logic                 unused_addr;

    always_comb begin
        unused_addr = ^sdr_addr;
        cmd    = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
        is_lmr = (cmd == 4'b0000);
        is_ref = (cmd == 4'b0001);
        is_pre = (cmd == 4'b0010);
        is_act = (cmd == 4'b0011);
        is_wr  = (cmd == 4'b0100);
        is_rd  = (cmd == 4'b0101);
        is_bst = (cmd == 4'b0110);

        any_open = 1'b0;
        for (int unsigned i = 0; i < 4; i++)
            if (bank_st[i] == BANK_ACTIVE) any_open = 1'b1;
        bank_open = (bank_st[sdr_ba] == BANK_ACTIVE);
`ifdef SDR_DEV_INIT_CHK_EN
        init_block = !mode_set && (is_act || is_rd || is_wr || is_bst);
`else
        init_block = 1'b0;
`endif
        rd_ok    = is_rd && bank_open && !init_block;
        wr_ok    = is_wr && bank_open && !init_block;
        mode_bad = sdr_addr[2] || (sdr_addr[6:5] != 2'b01);
        rd_busy  = sdr_dq_oe || p0_v || (cl3 && p1_v);

        err_now = ERR_NONE;
        if (init_block)                                    err_now = ERR_INIT;
        else if (is_act && bank_open)                      err_now = ERR_ACT_OPEN;
        else if ((is_rd || is_wr) && !bank_open)           err_now = ERR_BANK_IDLE;
        else if ((is_ref || is_lmr) && any_open)           err_now = ERR_BANKS_OPEN;
        else if (is_lmr && mode_bad)                       err_now = ERR_MODE;
        else if (wr_ok && rd_busy)                         err_now = ERR_WR_RD;

        term = rd_ok || wr_ok || (is_bst && !init_block) ||
               (is_pre && (sdr_addr[10] || sdr_ba == bst_bank));

        case (bl_code)
            2'd0:    bl_mask = 3'd0;
            2'd1:    bl_mask = 3'd1;
            2'd2:    bl_mask = 3'd3;
            default: bl_mask = 3'd7;
        endcase
        mask_ext = {{(COL_W-3){1'b0}}, bl_mask};

        // Command beat takes priority; a running burst only advances when nothing terminated it.
        beat_v    = 1'b0;
        beat_wr   = 1'b0;
        beat_bank = bst_bank;
        beat_col  = bst_col;
        if (rd_ok || wr_ok) begin
            beat_v    = 1'b1;
            beat_wr   = wr_ok;
            beat_bank = sdr_ba;
            beat_col  = sdr_addr[COL_W-1:0];
        end else if (bst_active && !term) begin
            beat_v  = 1'b1;
            beat_wr = bst_wr;
        end
        beat_addr = {beat_bank, bank_row[beat_bank], beat_col};
        col_next  = (beat_col & ~mask_ext) | ((beat_col + COL_W'(1)) & mask_ext);

        src_v = cl3 ? p1_v : p0_v;
        src_a = cl3 ? p1_a : p0_a;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                bank_st[i]  <= BANK_IDLE;
                bank_row[i] <= '0;
            end
            bl_code      <= 2'd0;
            cl3          <= 1'b0;
`ifdef SDR_DEV_INIT_CHK_EN
            mode_set     <= 1'b0;
`endif
            bst_active   <= 1'b0;
            bst_wr       <= 1'b0;
            bst_ap       <= 1'b0;
            bst_bank     <= 2'd0;
            bst_col      <= '0;
            bst_cnt      <= 3'd0;
            p0_v         <= 1'b0;
            p1_v         <= 1'b0;
            p0_a         <= '0;
            p1_a         <= '0;
            dqm_d        <= '0;
            sdr_dq_out   <= '0;
            sdr_dq_oe    <= 1'b0;
            cmd_err      <= 1'b0;
            cmd_err_code <= 3'd0;
        end else if (sdr_cke) begin
            if (is_act && !init_block && !bank_open) begin
                bank_st[sdr_ba]  <= BANK_ACTIVE;
                bank_row[sdr_ba] <= sdr_addr[ROW_W-1:0];
            end
            if (is_pre)
                for (int unsigned i = 0; i < 4; i++)
                    if (sdr_addr[10] || sdr_ba == 2'(i)) bank_st[i] <= BANK_IDLE;
            if (is_lmr && !any_open) begin
                bl_code <= sdr_addr[2] ? 2'd0 : sdr_addr[1:0];
                cl3     <= (sdr_addr[6:4] == 3'd3);
`ifdef SDR_DEV_INIT_CHK_EN
                mode_set <= 1'b1;
`endif
            end
            if (err_now != ERR_NONE && !cmd_err) begin
                cmd_err      <= 1'b1;
                cmd_err_code <= err_now;
            end

            // Burst bookkeeping runs after the command so auto-precharge closes the bank last.
            if (rd_ok || wr_ok) begin
                bst_active <= (bl_code != 2'd0);
                bst_wr     <= wr_ok;
                bst_bank   <= sdr_ba;
                bst_col    <= col_next;
                bst_cnt    <= bl_mask;
                bst_ap     <= sdr_addr[10];
                if (bl_code == 2'd0 && sdr_addr[10]) bank_st[sdr_ba] <= BANK_IDLE;
            end else if (beat_v) begin
                bst_col <= col_next;
                bst_cnt <= bst_cnt - 3'd1;
                if (bst_cnt == 3'd1) begin
                    bst_active <= 1'b0;
                    if (bst_ap) bank_st[bst_bank] <= BANK_IDLE;
                end
            end else if (term) begin
                bst_active <= 1'b0;
            end

            p0_v  <= beat_v && !beat_wr;
            p0_a  <= beat_addr;
            p1_v  <= p0_v && !wr_ok;
            p1_a  <= p0_a;
            dqm_d <= sdr_dqm;
            if (wr_ok) begin
                sdr_dq_oe <= 1'b0;
            end else begin
                sdr_dq_oe <= src_v && !(&dqm_d);
                if (src_v) sdr_dq_out <= mem[src_a];
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdr_cke && beat_v && beat_wr)
            for (int unsigned b = 0; b < SDR_BW; b++)
                if (!sdr_dqm[b]) mem[beat_addr][b*8 +: 8] <= sdr_dq_in[b*8 +: 8];
    end
endmodule
